dmem_wait: RTL and testbench

Parametrised data memory for the CPU data path. Replaces the fixed 256x16 always-ready array with a request/done handshake, programmable wait states, byte-lane write enables and out-of-range error reporting. Sits between the load/store unit and the data array. Gives the pipeline a realistic stall source and supports byte stores.

---
 rtl/dmem_wait.sv | 158 +++++++++++++++
 tb/tb_dmem_wait.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait.sv
// Data memory with request/done handshake, programmable wait states,
// byte-lane write enables and out-of-range error reporting.
module dmem_wait #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W/8-1:0]    be,
  output logic                   ready,
  output logic                   done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  // Configuration sanity checks at elaboration.
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_wait: WAIT_CYCLES must be in 0..15");
  end
  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_width
    $error("dmem_wait: DATA_W must be a non-zero multiple of 8");
  end
  if (64'(DEPTH) > (64'(1) << ADDR_W) || DEPTH == 0) begin : g_bad_depth
    $error("dmem_wait: DEPTH must be in 1..2^ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_accept;
  logic                w_access;
  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [LANES-1:0]    r_be;

  logic                r_ready;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  // Array contents start at zero at time 0 and are never cleared by rst.
  logic [DATA_W-1:0]   r_mem [DEPTH] = '{default: '0};

  assign w_in_range = ({1'b0, r_addr} < DEPTH_X);
  assign w_idx      = r_addr[IDX_W-1:0];

  // Next-state logic: accept in IDLE, count down in WAIT, complete in ACCESS.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(WAIT_CYCLES) - CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        w_access    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and wait-counter registers; rst aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request so inputs may change after acceptance.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_be    <= be;
    end
  end

  // Byte-lane write into the array on the completing edge.
  always_ff @(posedge clk) begin
    if (!rst && w_access && r_we && w_in_range) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (r_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered handshake outputs; rdata only changes on a completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_done  <= w_access;
      r_err   <= w_access & ~w_in_range;
      if (w_access && !r_we) begin
        r_rdata <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_dmem_wait.sv
// Self-checking bench for dmem_wait: three builds (0, 1 and 15 wait states)
// share one stimulus stream and are each compared against a cycle-level
// behavioural model every clock.
module tb_dmem_wait;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned DEP = 256;
  localparam int          NI  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we  = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    be    = '0;

  logic [NI-1:0] ready_v;
  logic [NI-1:0] done_v;
  logic [NI-1:0] err_v;
  logic [DW-1:0] rdata_v [NI];

  dmem_wait #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_v[0]), .done(done_v[0]), .rdata(rdata_v[0]), .err(err_v[0]));
  dmem_wait #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_v[1]), .done(done_v[1]), .rdata(rdata_v[1]), .err(err_v[1]));
  dmem_wait #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_v[2]), .done(done_v[2]), .rdata(rdata_v[2]), .err(err_v[2]));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: an accepted request completes WAIT_CYCLES+1 edges later.
  int unsigned   wc [NI] = '{0, 1, 15};
  int            rem [NI];
  logic          m_we [NI];
  int            m_addr [NI];
  logic [DW-1:0] m_wd [NI];
  logic [1:0]    m_be [NI];
  logic [DW-1:0] mm [NI][DEP];
  logic          e_ready [NI];
  logic          e_done [NI];
  logic          e_err [NI];
  logic [DW-1:0] e_rdata [NI];
  logic [DW-1:0] m_word;
  bit            chk_en = 1'b0;

  // Advance the model on each edge, then compare every build just after it.
  always @(posedge clk) begin
    for (int n = 0; n < NI; n++) begin
      e_done[n] = 1'b0;
      e_err[n]  = 1'b0;
      if (rst) begin
        rem[n]     = 0;
        e_rdata[n] = '0;
      end else if (rem[n] > 0) begin
        rem[n]--;
        if (rem[n] == 0) begin
          e_done[n] = 1'b1;
          if (m_addr[n] >= int'(DEP)) begin
            e_err[n] = 1'b1;
            if (!m_we[n]) e_rdata[n] = '0;
          end else if (m_we[n]) begin
            m_word = mm[n][m_addr[n]];
            for (int b = 0; b < 2; b++) begin
              if (m_be[n][b]) m_word[8*b +: 8] = m_wd[n][8*b +: 8];
            end
            mm[n][m_addr[n]] = m_word;
          end else begin
            e_rdata[n] = mm[n][m_addr[n]];
          end
        end
      end else if (req) begin
        rem[n]    = int'(wc[n]) + 1;
        m_we[n]   = we;
        m_addr[n] = int'(addr);
        m_wd[n]   = wdata;
        m_be[n]   = be;
      end
      e_ready[n] = (rem[n] == 0);
    end
    #1;
    if (chk_en) begin
      for (int n = 0; n < NI; n++) begin
        check($sformatf("inst%0d ready", n), 32'(ready_v[n]), 32'(e_ready[n]));
        check($sformatf("inst%0d done", n),  32'(done_v[n]),  32'(e_done[n]));
        check($sformatf("inst%0d err", n),   32'(err_v[n]),   32'(e_err[n]));
        check($sformatf("inst%0d rdata", n), 32'(rdata_v[n]), 32'(e_rdata[n]));
      end
    end
  end

  // Wait (bounded) until every build is idle, then present one request for one edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] b);
    int t = 0;
    while (ready_v != 3'b111 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready timeout", 32'(ready_v), 32'h7);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0;
    we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom); be = 2'($urandom);
  endtask

  // Edges from the accepting edge until the 1-wait-state build reports done.
  task automatic wait_done(output logic [DW-1:0] rd, output logic e, output int edges);
    edges = 0; rd = '0; e = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk);
      #1;
      if (done_v[1]) begin
        edges = t; rd = rdata_v[1]; e = err_v[1];
        break;
      end
    end
    if (edges == 0) check("done timeout", 32'(done_v[1]), 32'h1);
    @(negedge clk);
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            ed;
  int            lat [NI];
  int            cnt [NI];

  initial begin
    for (int n = 0; n < NI; n++) begin
      rem[n] = 0; e_rdata[n] = '0; e_ready[n] = 1'b1; e_done[n] = 1'b0; e_err[n] = 1'b0;
      for (int i = 0; i < int'(DEP); i++) mm[n][i] = '0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset ready", 32'(ready_v[1]), 32'h1);
    check("reset done",  32'(done_v[1]),  32'h0);
    check("reset err",   32'(err_v[1]),   32'h0);
    check("reset rdata", 32'(rdata_v[1]), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic write timing and read-back.
    issue(1'b1, 16'd5, 16'hBEEF, 2'b11);
    check("busy after k", 32'(ready_v[1]), 32'h0);
    @(negedge clk);
    check("busy after k+1", 32'(ready_v[1]), 32'h0);
    check("no done after k+1", 32'(done_v[1]), 32'h0);
    @(negedge clk);
    check("done after k+2", 32'(done_v[1]), 32'h1);
    check("ready after k+2", 32'(ready_v[1]), 32'h1);
    check("write err", 32'(err_v[1]), 32'h0);
    issue(1'b0, 16'd5, 16'h0, 2'b00);
    wait_done(rd, er, ed);
    check("read 5", 32'(rd), 32'hBEEF);
    check("read 5 err", 32'(er), 32'h0);
    check("read latency", 32'(ed), 32'd2);

    // Byte lanes.
    issue(1'b1, 16'd7, 16'h1234, 2'b11); wait_done(rd, er, ed);
    issue(1'b1, 16'd7, 16'hABCD, 2'b01); wait_done(rd, er, ed);
    issue(1'b0, 16'd7, 16'h0, 2'b00);    wait_done(rd, er, ed);
    check("lane merge", 32'(rd), 32'h12CD);
    issue(1'b1, 16'd7, 16'hFFFF, 2'b00); wait_done(rd, er, ed);
    check("be=0 done latency", 32'(ed), 32'd2);
    issue(1'b0, 16'd7, 16'h0, 2'b00);    wait_done(rd, er, ed);
    check("be=0 no-op", 32'(rd), 32'h12CD);

    // Out of range.
    issue(1'b1, 16'd300, 16'hDEAD, 2'b11); wait_done(rd, er, ed);
    check("oor write err", 32'(er), 32'h1);
    issue(1'b0, 16'd300, 16'h0, 2'b00);    wait_done(rd, er, ed);
    check("oor read err", 32'(er), 32'h1);
    check("oor read data", 32'(rd), 32'h0);
    issue(1'b0, 16'd44, 16'h0, 2'b00);     wait_done(rd, er, ed);
    check("no alias 44", 32'(rd), 32'h0);
    check("no alias err", 32'(er), 32'h0);

    // rdata holds across an intervening write.
    issue(1'b0, 16'd5, 16'h0, 2'b00);      wait_done(rd, er, ed);
    issue(1'b1, 16'd6, 16'h1111, 2'b11);   wait_done(rd, er, ed);
    check("rdata hold", 32'(rd), 32'hBEEF);

    // Reset while waiting aborts the write.
    issue(1'b1, 16'd3, 16'h5555, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check("abort no done", 32'(done_v[1]), 32'h0);
    check("abort ready", 32'(ready_v[1]), 32'h1);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort stays quiet", 32'(done_v), 32'h0);
    end
    issue(1'b0, 16'd3, 16'h0, 2'b00);      wait_done(rd, er, ed);
    check("abort kept old", 32'(rd), 32'h0);

    // Latency per build.
    issue(1'b0, 16'd5, 16'h0, 2'b00);
    for (int n = 0; n < NI; n++) lat[n] = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      for (int n = 0; n < NI; n++) if (done_v[n] && lat[n] == 0) lat[n] = e;
    end
    check("latency w0", 32'(lat[0]), 32'd1);
    check("latency w1", 32'(lat[1]), 32'd2);
    check("latency w15", 32'(lat[2]), 32'd16);
    @(negedge clk);

    // Continuous req: one access per 2+WAIT_CYCLES edges, extra req ignored.
    repeat (20) @(negedge clk);
    for (int n = 0; n < NI; n++) cnt[n] = 0;
    req = 1'b1; we = 1'b0; addr = '0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      for (int n = 0; n < NI; n++) cnt[n] += int'(done_v[n]);
      @(negedge clk);
      addr = AW'((int'(addr) + 1) % 3);
    end
    req = 1'b0;
    check("throughput w0", 32'(cnt[0]), 32'd15);
    check("throughput w1", 32'(cnt[1]), 32'd10);
    check("throughput w15", 32'(cnt[2]), 32'd1);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 199) == 0);
      req   = ($urandom_range(0, 2) != 0);
      we    = 1'($urandom);
      addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(250, 310))
                                          : AW'($urandom_range(0, 15));
      wdata = DW'($urandom);
      be    = 2'($urandom);
    end
    rst = 1'b0; req = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
